// File: rtl/sccb_target.sv
// SCCB/I2C write-only target: synchronises SCL/SDA, decodes START/STOP, matches DEV_ADDR and writes
// sub-address + data bytes into a local register file. Define SCCB_TARGET_ACK_EN to drive ACK low.
module sccb_target #(
  parameter logic [7:0] DEV_ADDR    = 8'h42,
  parameter int         SYNC_STAGES = 2,
  parameter int         REG_DEPTH   = 256
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       wr_en_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  input  logic [7:0] rd_addr_i,
  output logic [7:0] rd_data_o,
  output logic       busy_o,
  output logic       err_o
);

  localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
`ifdef SCCB_TARGET_ACK_EN
  localparam logic ACK_EN = 1'b1;
`else
  localparam logic ACK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, DEV_BYTE, DEV_ACK, SUB_BYTE, SUB_ACK, DATA_BYTE, DATA_ACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  state_t                 r_state;
  logic [3:0]             r_bitcnt;
  logic [6:0]             r_shift;
  logic [7:0]             r_addr;
  logic [7:0]             r_mem [REG_DEPTH];

  logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop, w_in_byte;
  logic [7:0]    w_byte;
  logic [AW-1:0] w_widx, w_ridx;

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_in_byte  = (r_state == DEV_BYTE) || (r_state == SUB_BYTE) || (r_state == DATA_BYTE);
  assign w_byte     = {r_shift, w_sda};
  assign w_widx     = AW'(wr_addr_o % REG_DEPTH);
  assign w_ridx     = AW'(rd_addr_i % REG_DEPTH);

  // Idle bus is high, so the synchronisers reset to 1 to avoid a false edge on release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_addr    <= '0;
      sda_oe    <= 1'b0;
      wr_en_o   <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
      busy_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      wr_en_o <= 1'b0;
      err_o   <= 1'b0;
      if (w_stop) begin
        r_state <= IDLE;
        busy_o  <= 1'b0;
        sda_oe  <= 1'b0;
        // The STOP's own SCL rise was counted as a bit, so 2..8 means 1..7 real bits.
        if (w_in_byte && r_bitcnt >= 4'd2) err_o <= 1'b1;
      end else if (w_start) begin
        r_state  <= DEV_BYTE;
        r_bitcnt <= '0;
        busy_o   <= 1'b1;
        sda_oe   <= 1'b0;
      end else if (w_scl_rise && w_in_byte && r_bitcnt < 4'd8) begin
        r_shift  <= w_byte[6:0];
        r_bitcnt <= r_bitcnt + 4'd1;
        if (r_bitcnt == 4'd7) begin
          case (r_state)
            DEV_BYTE: if (w_byte != DEV_ADDR) begin
              r_state <= IGNORE;
              err_o   <= 1'b1;
            end
            SUB_BYTE: r_addr <= w_byte;
            default: begin
              wr_en_o   <= 1'b1;
              wr_addr_o <= r_addr;
              wr_data_o <= w_byte;
              r_addr    <= r_addr + 8'd1;
            end
          endcase
        end
      end else if (w_scl_fall) begin
        case (r_state)
          DEV_BYTE:  if (r_bitcnt == 4'd8) begin r_state <= DEV_ACK;  sda_oe <= ACK_EN; end
          SUB_BYTE:  if (r_bitcnt == 4'd8) begin r_state <= SUB_ACK;  sda_oe <= ACK_EN; end
          DATA_BYTE: if (r_bitcnt == 4'd8) begin r_state <= DATA_ACK; sda_oe <= ACK_EN; end
          DEV_ACK:   begin r_state <= SUB_BYTE;  r_bitcnt <= '0; sda_oe <= 1'b0; end
          SUB_ACK:   begin r_state <= DATA_BYTE; r_bitcnt <= '0; sda_oe <= 1'b0; end
          DATA_ACK:  begin r_state <= DATA_BYTE; r_bitcnt <= '0; sda_oe <= 1'b0; end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_o) r_mem[w_widx] <= wr_data_o;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rd_data_o <= '0;
    else         rd_data_o <= r_mem[w_ridx];
  end

endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: bit-banged SCCB master, transaction-level model of expected writes,
// errors and ACKs, plus a per-cycle compare process on the strobe/error/SDA-drive outputs.
module tb_sccb_target;
  localparam int Q = 4;
`ifdef SCCB_TARGET_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic clk = 1'b0, resetn = 1'b0, scl_drv = 1'b1, sda_drv = 1'b1;
  logic [7:0] rd_addr = '0;
  logic sda_oe, wr_en, busy, err, sda_bus;
  logic [7:0] wr_addr, wr_data, rd_data;

  assign sda_bus = sda_drv & ~sda_oe;

  sccb_target dut (
    .clk(clk), .resetn(resetn), .scl_i(scl_drv), .sda_i(sda_bus), .sda_oe(sda_oe),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] a; logic [7:0] d; int c; } wr_t;
  wr_t expq[$];
  wr_t ce;
  logic [7:0] mdl [256];
  bit mvalid [256];
  logic [7:0] tb_bytes [8];
  int nvec = 0, nerr = 0, cyc = 0;
  int err_exp = 0, err_seen = 0, ack_seen = 0, wr_seen = 0;
  logic prev_oe = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle: strobes must match the queued model writes, SDA drive obeys the ACK rules.
  always @(negedge clk) begin
    if (resetn) begin
      if (wr_en) begin
        wr_seen++;
        if (expq.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          ce = expq.pop_front();
          chk("wr_addr", wr_addr, ce.a);
          chk("wr_data", wr_data, ce.d);
          chk("wr_latency", cyc, ce.c + 3);
        end
      end
      if (err) err_seen++;
      if (!ACK) chk("sda_oe_never", sda_oe, 0);
      else if (sda_oe !== prev_oe) chk("oe_change_scl_low", scl_drv, 0);
      prev_oe = sda_oe;
    end else prev_oe = 1'b0;
  end

  task automatic half(); repeat (Q) @(negedge clk); endtask

  task automatic bus_start();
    sda_drv = 1'b1; half(); scl_drv = 1'b1; half(); sda_drv = 1'b0; half(); scl_drv = 1'b0; half();
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; half(); scl_drv = 1'b1; half(); sda_drv = 1'b1; half(); half();
  endtask

  task automatic bus_bit(input logic b, input bit push, input logic [7:0] wa, input logic [7:0] wd,
                         output logic sampled);
    wr_t w;
    sda_drv = b; half();
    scl_drv = 1'b1;
    if (push) begin w.a = wa; w.d = wd; w.c = cyc; expq.push_back(w); end
    half(); sampled = sda_bus; half();
    scl_drv = 1'b0; half();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit exp_ack, input bit exp_wr, input logic [7:0] wa);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], exp_wr && i == 0, wa, b, s);
    bus_bit(1'b1, 1'b0, 8'h00, 8'h00, s);
    chk("ack_bit", s, (ACK && exp_ack) ? 0 : 1);
    if (!s) ack_seen++;
  endtask

  // Model: an addressed transaction ACKs every byte and writes data bytes from sub-address upward.
  task automatic xfer(input int n, input int pbits, input logic [7:0] pbyte, input bit do_stop);
    bit addressed;
    logic [7:0] wa;
    logic s;
    addressed = (tb_bytes[0] == 8'h42);
    bus_start();
    for (int i = 0; i < n; i++) begin
      wa = tb_bytes[1] + 8'(i - 2);
      if (addressed && i >= 2) begin mdl[wa] = tb_bytes[i]; mvalid[wa] = 1'b1; end
      if (i == 0 && !addressed) err_exp++;
      send_byte(tb_bytes[i], addressed, addressed && i >= 2, wa);
    end
    for (int i = 0; i < pbits; i++) bus_bit(pbyte[7-i], 1'b0, 8'h00, 8'h00, s);
    if (pbits > 0 && addressed) err_exp++;
    if (do_stop) bus_stop();
    repeat (6) @(negedge clk);
    chk("err_count", err_seen, err_exp);
    chk("writes_drained", expq.size(), 0);
    chk("busy", busy, !do_stop);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
    @(negedge clk); rd_addr = a; @(negedge clk);
    chk(name, rd_data, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int w0, a0, e0;
    logic s;
    for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_sda_oe", sda_oe, 0); chk("rst_wr_en", wr_en, 0); chk("rst_busy", busy, 0);
    chk("rst_err", err, 0); chk("rst_wr_addr", wr_addr, 0); chk("rst_wr_data", wr_data, 0);

    // Basic write 42,12,80
    w0 = wr_seen; a0 = ack_seen;
    tb_bytes[0] = 8'h42; tb_bytes[1] = 8'h12; tb_bytes[2] = 8'h80;
    xfer(3, 0, 8'h00, 1'b1);
    chk("basic_one_write", wr_seen - w0, 1);
    chk("basic_ack_windows", ack_seen - a0, ACK ? 3 : 0);
    rd_chk("basic_read12", 8'h12, 8'h80);

    // Wrong device address: ignored
    w0 = wr_seen; a0 = ack_seen; e0 = err_seen;
    tb_bytes[0] = 8'h60;
    xfer(3, 0, 8'h00, 1'b1);
    chk("nack_no_write", wr_seen - w0, 0);
    chk("nack_no_ack", ack_seen - a0, 0);
    chk("nack_one_err", err_seen - e0, 1);
    rd_chk("nack_reg12_kept", 8'h12, 8'h80);

    // Burst with address wrap
    w0 = wr_seen;
    tb_bytes[0] = 8'h42; tb_bytes[1] = 8'hFF; tb_bytes[2] = 8'hAA; tb_bytes[3] = 8'h55;
    xfer(4, 0, 8'h00, 1'b1);
    chk("wrap_two_writes", wr_seen - w0, 2);
    rd_chk("wrap_regFF", 8'hFF, 8'hAA);
    rd_chk("wrap_reg00", 8'h00, 8'h55);

    // Partial data byte then STOP, followed by a fresh full write
    w0 = wr_seen; e0 = err_seen;
    tb_bytes[0] = 8'h42; tb_bytes[1] = 8'h20;
    xfer(2, 4, 8'hA0, 1'b1);
    chk("partial_no_write", wr_seen - w0, 0);
    chk("partial_one_err", err_seen - e0, 1);
    tb_bytes[2] = 8'h33;
    xfer(3, 0, 8'h00, 1'b1);
    rd_chk("restart_reg20", 8'h20, 8'h33);

    // Reset after 5 bits of the sub-address byte
    w0 = wr_seen;
    bus_start();
    send_byte(8'h42, 1'b1, 1'b0, 8'h00);
    for (int i = 7; i >= 3; i--) bus_bit(s_bit(8'h05, i), 1'b0, 8'h00, 8'h00, s);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_sda_oe", sda_oe, 0);
    chk("rst_mid_busy", busy, 0);
    resetn = 1'b1;
    for (int i = 2; i >= 0; i--) bus_bit(s_bit(8'h05, i), 1'b0, 8'h00, 8'h00, s);
    bus_bit(1'b1, 1'b0, 8'h00, 8'h00, s);
    bus_bit(1'b1, 1'b0, 8'h00, 8'h00, s);
    bus_stop();
    repeat (4) @(negedge clk);
    chk("rst_mid_no_write", wr_seen - w0, 0);
    chk("rst_mid_idle", busy, 0);
    tb_bytes[0] = 8'h42; tb_bytes[1] = 8'h05; tb_bytes[2] = 8'hA5;
    xfer(3, 0, 8'h00, 1'b1);
    rd_chk("rst_recover_reg05", 8'h05, 8'hA5);

    // Randomised transactions
    for (int t = 0; t < 25; t++) begin
      int n, pb;
      bit stp;
      if ($urandom_range(0, 4) == 0) begin
        tb_bytes[0] = 8'($urandom_range(0, 255));
        if (tb_bytes[0] == 8'h42) tb_bytes[0] = 8'h43;
      end else tb_bytes[0] = 8'h42;
      tb_bytes[1] = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 6);
      for (int i = 2; i < 6; i++) tb_bytes[i] = 8'($urandom_range(0, 255));
      pb = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 6) : 0;
      stp = (t == 24) || (pb > 0) || ($urandom_range(0, 3) != 0);
      xfer(n, pb, 8'($urandom_range(0, 255)), stp);
    end
    for (int a = 0; a < 256; a++)
      if (mvalid[a]) rd_chk("rand_readback", 8'(a), mdl[a]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  function automatic logic s_bit(input logic [7:0] v, input int i);
    return v[i];
  endfunction

endmodule
